// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants, the buffered load-result entry type and a
//            pointer-width helper for the writeback arbiter.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_WIDTH  = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_WIDTH-1:0]  data;
  } wb_entry_t;

  // A one-entry buffer still needs a 1-bit pointer to be a legal vector.
  function automatic int wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular buffer of load results. Entries leave strictly in the
//            order they arrived. Every slot's rd and valid bit are exported so
//            the arbiter can check for pending writes.
// Ports    : clk, rst_n (sync, active-low)
//            push_i / push_entry_i : write an entry at the tail (ignored if full)
//            pop_i                 : drop the head entry (ignored if empty)
//            head_o                : entry at the head
//            full_o, empty_o, count_o
//            ent_valid_o, ent_rd_o : per-slot occupancy and destination
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push_i,
  input  wb_entry_t                       push_entry_i,
  input  logic                            pop_i,
  output wb_entry_t                       head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [CNT_W-1:0]                count_o,
  output logic [DEPTH-1:0]                ent_valid_o,
  output logic [DEPTH-1:0][WB_ADDR_W-1:0] ent_rd_o
);

  localparam int PTR_W = wb_ptr_w(DEPTH);

  wb_entry_t         mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      // With push blocked when full and pop blocked when empty, a same-cycle
      // push and pop always address different slots.
      if (do_push) begin
        mem_q[wr_ptr_q]   <= push_entry_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign ent_valid_o = valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_rd_o[i] = mem_q[i].rd;
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Drives the register file's single write port from the ALU path
//            (priority, no back-pressure) and a buffered load path, and
//            reports pending writes to decode.
// Ports    : clk, rst_n (sync, active-low)
//            alu_valid/alu_rd/alu_data          : ALU result
//            lsu_valid/lsu_ready/lsu_rd/lsu_data : load result handshake
//            RegWrite/as3/WD                    : registered write port
//            drain_req                          : load buffer full
//            chk_rs1/chk_rs2/pend_hit           : pending-write check
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH  = WB_WIDTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [WIDTH-1:0]  lsu_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] as3,
  output logic [WIDTH-1:0]  WD,
  output logic              drain_req,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              pend_hit
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t                       push_entry;
  wb_entry_t                       head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [CNT_W-1:0]                fifo_count;
  logic [DEPTH-1:0]                ent_valid;
  logic [DEPTH-1:0][WB_ADDR_W-1:0] ent_rd;
  logic                            push;
  logic                            pop;
  logic                            alu_sel;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] as3_q, as3_d;
  logic [WIDTH-1:0]  wd_q, wd_d;

  // Loads to x0 complete the handshake but are never stored.
  assign lsu_ready  = rst_n && !fifo_full;
  assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign push_entry = '{rd: lsu_rd, data: lsu_data};

  // Any alu_valid, even one aimed at x0, owns the port and blocks the pop.
  assign alu_sel = alu_valid && (alu_rd != '0);
  assign pop     = !alu_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .ent_valid_o  (ent_valid),
    .ent_rd_o     (ent_rd)
  );

  assign drain_req = (fifo_count == CNT_W'(DEPTH));

  always_comb begin
    regwrite_d = 1'b0;
    as3_d      = as3_q;
    wd_d       = wd_q;
    if (alu_sel) begin
      regwrite_d = 1'b1;
      as3_d      = alu_rd;
      wd_d       = alu_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      as3_d      = head.rd;
      wd_d       = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      as3_q      <= '0;
      wd_q       <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      as3_q      <= as3_d;
      wd_q       <= wd_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign as3      = as3_q;
  assign WD       = wd_q;

  // The output stage counts as pending: the register file only takes the
  // value at the next edge. A zero register never matches.
  always_comb begin
    pend_hit = 1'b0;
    if (regwrite_q && (as3_q != '0) && ((as3_q == chk_rs1) || (as3_q == chk_rs2)))
      pend_hit = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] != '0) &&
          ((ent_rd[i] == chk_rs1) || (ent_rd[i] == chk_rs2)))
        pend_hit = 1'b1;
    end
  end

  a_no_alu_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(alu_valid && drain_req)
  ) else $error("wb_arbiter: alu_valid asserted while drain_req is high");

endmodule
`default_nettype wire
